// File: rtl/display_scan_controller.sv
// Time-multiplexed digit scan for the seven-segment path: per-slot digit index,
// active-low anode drive with leading blanking and 16-level PWM brightness.
module display_scan_controller #(
    parameter int NUM_DIGITS    = 7,
    parameter int PRESCALE_BITS = 17,
    parameter int BLANK_CYCLES  = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] brightness,
    output logic [2:0] refreshcounter,
    output logic [7:0] anode,
    output logic       digit_tick
);

    localparam logic [PRESCALE_BITS-1:0] PRE_MAX    = '1;
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE    = PRESCALE_BITS'(1);
    localparam logic [PRESCALE_BITS-1:0] BLANK      = PRESCALE_BITS'(BLANK_CYCLES);
    localparam logic [2:0]               LAST_DIGIT = 3'(NUM_DIGITS - 1);
    // Positions beyond the populated digits can never be driven low.
    localparam logic [7:0]               DIGIT_MASK = 8'((16'd1 << NUM_DIGITS) - 16'd1);

    logic [PRESCALE_BITS-1:0] prescaler_q, prescaler_d;
    logic [2:0]               refresh_q, refresh_d;
    logic [3:0]               bright_q, bright_d;
    logic [7:0]               anode_q, anode_d;
    logic                     tick_q, tick_d;

    logic       slot_end;
    logic       lit;
    logic [3:0] phase;

    always_comb begin
        slot_end    = enable && (prescaler_q == PRE_MAX);
        phase       = prescaler_q[PRESCALE_BITS-1 -: 4];
        lit         = enable && (prescaler_q >= BLANK) && (phase <= bright_q);

        prescaler_d = enable ? prescaler_q + PRE_ONE : prescaler_q;
        refresh_d   = refresh_q;
        bright_d    = bright_q;
        if (slot_end) begin
            refresh_d = (refresh_q == LAST_DIGIT) ? 3'd0 : refresh_q + 3'd1;
            // Brightness only takes effect at a slot boundary so a slot never changes duty mid-way.
            bright_d  = brightness;
        end

        anode_d = lit ? ~((8'd1 << refresh_q) & DIGIT_MASK) : 8'hFF;
        tick_d  = slot_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
            refresh_q   <= 3'd0;
            bright_q    <= 4'hF;
            anode_q     <= 8'hFF;
            tick_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            refresh_q   <= refresh_d;
            bright_q    <= bright_d;
            anode_q     <= anode_d;
            tick_q      <= tick_d;
        end
    end

    assign refreshcounter = refresh_q;
    assign anode          = anode_q;
    assign digit_tick     = tick_q;

endmodule
